// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter that shares one memory-stage data port among four
// requesters. It produces a one-hot grant and the binary select for the 4:1
// data mux in front of the port. Two fairness rules apply:
//   * An owner that has held the port for MAX_BURST consecutive cycles is
//     preempted if another requester is waiting.
//   * Every change of owner passes through a one-cycle turnaround (GAP) with no
//     grant asserted.
// All outputs are registered.
//
// Optional feature macro: MEM_ARB_LOCK_EN
//   When defined, a Lock input is present. While the current owner holds
//   Lock=1 it cannot be preempted by the burst limit. Its burst counter
//   saturates at MAX_BURST, so once Lock drops a waiting requester can preempt
//   it immediately. A voluntary release still ends the grant. Lock is ignored
//   outside the GRANT state.
//   When undefined, there is no Lock port and the burst limit always applies.
//
// Parameters
//   MAX_BURST     maximum consecutive grant cycles while another requester
//                 waits (must be >= 1)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   Req[3:0]      level request per requester, held until its transfer is done
//   Lock          (MEM_ARB_LOCK_EN only) owner blocks burst preemption
//   Grant[3:0]    registered one-hot grant, all zeros when there is no owner
//   Mux_Selector  registered binary index of the owner; keeps its value during
//                 GAP and IDLE so the data mux does not glitch
//   Busy          1 while the arbiter is in the GRANT state
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Req,
`ifdef MEM_ARB_LOCK_EN
  input  logic       Lock,
`endif
  output logic [3:0] Grant,
  output logic [1:0] Mux_Selector,
  output logic       Busy
);

  localparam int CNT_BITS = $clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_BURST);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [3:0]            grant_reg, grant_next;
  logic [1:0]            sel_reg,   sel_next;
  logic [1:0]            last_reg,  last_next;
  logic [CNT_BITS-1:0]   count_reg, count_next;
  logic                  busy_reg,  busy_next;

  // ---------------------------------------------------------------------------
  // Round-robin search. Slot gi of the scan looks at requester last+1+gi
  // (mod 4). The 2-bit add wraps naturally, so slot 0 is the highest priority
  // and the previous owner always lands in slot 3, the lowest priority.
  // ---------------------------------------------------------------------------
  logic [1:0] scan_idx [4];
  logic [3:0] scan_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      assign scan_idx[gi] = last_reg + 2'(gi + 1);
      assign scan_hit[gi] = Req[scan_idx[gi]];
    end
  endgenerate

  logic       pick_valid;
  logic [1:0] pick_idx;

  always_comb begin
    pick_valid = |scan_hit;
    pick_idx   = scan_idx[0];
    // Walk from the lowest-priority slot to the highest so the earliest hit wins.
    for (int k = 3; k >= 0; k--) begin
      if (scan_hit[k]) begin
        pick_idx = scan_idx[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conditions evaluated while an owner holds the port. sel_reg is the owner's
  // index and grant_reg is its one-hot mask.
  // ---------------------------------------------------------------------------
  logic owner_req;
  logic others_req;
  logic lock_active;

  assign owner_req  = Req[sel_reg];
  assign others_req = |(Req & ~grant_reg);

`ifdef MEM_ARB_LOCK_EN
  assign lock_active = Lock;
`else
  assign lock_active = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    count_next = count_reg;
    busy_next  = busy_reg;

    unique case (state_reg)
      // IDLE and GAP arbitrate in the same way. The only difference is that GAP
      // always lasts a single cycle.
      IDLE, GAP: begin
        if (pick_valid) begin
          state_next = GRANT;
          grant_next = 4'b0001 << pick_idx;
          sel_next   = pick_idx;
          last_next  = pick_idx;
          count_next = CNT_ONE;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
          grant_next = 4'b0000;
          busy_next  = 1'b0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Release. This takes priority over the burst limit. Mux_Selector
          // keeps its value through the gap.
          state_next = GAP;
          grant_next = 4'b0000;
          busy_next  = 1'b0;
        end else if (lock_active) begin
          // Locked owner: no preemption. Saturating the counter means the
          // limit takes effect on the first unlocked cycle.
          if (count_reg != CNT_MAX) begin
            count_next = count_reg + CNT_ONE;
          end
        end else if (count_reg == CNT_MAX) begin
          if (others_req) begin
            // Burst limit reached while someone else waits: preempt. Last
            // already points at this owner, so it becomes the lowest priority.
            state_next = GAP;
            grant_next = 4'b0000;
            busy_next  = 1'b0;
          end else begin
            // Only one requester: restart the burst count without a gap.
            count_next = CNT_ONE;
          end
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= 4'b0000;
      sel_reg   <= 2'd0;
      last_reg  <= 2'd3;
      count_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      count_reg <= count_next;
      busy_reg  <= busy_next;
    end
  end

  assign Grant        = grant_reg;
  assign Mux_Selector = sel_reg;
  assign Busy         = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter with MAX_BURST = 8. Stimulus is
// applied on the falling edge of clk. At the same time, the output values
// expected after the next rising edge are pushed into a scoreboard queue. A
// separate monitor samples the outputs 1 time unit after each rising edge and
// compares them with the oldest queued entry. The bench prints one line per
// compared vector.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic [1:0] Mux_Selector;
  logic       Busy;
`ifdef MEM_ARB_LOCK_EN
  logic       lock;
`endif

  mem_port_arbiter #(.MAX_BURST(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .Req          (Req),
`ifdef MEM_ARB_LOCK_EN
    .Lock         (lock),
`endif
    .Grant        (Grant),
    .Mux_Selector (Mux_Selector),
    .Busy         (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t  sb_q   [$];
  string name_q [$];

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard monitor
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        if (Grant !== e.grant || Mux_Selector !== e.sel || Busy !== e.busy) begin
          miscompares++;
          $display("FAIL %s: got Grant=%b Sel=%0d Busy=%b, expected Grant=%b Sel=%0d Busy=%b",
                   nm, Grant, Mux_Selector, Busy, e.grant, e.sel, e.busy);
        end else begin
          $display("ok   %s: Grant=%b Sel=%0d Busy=%b", nm, Grant, Mux_Selector, Busy);
        end
      end
    end
  end

  // Apply one input vector and record the outputs expected after the next edge.
  task automatic step(input logic r, input logic [3:0] q,
                      input logic [3:0] eg, input logic [1:0] es, input logic eb,
                      input string nm);
    exp_t e;
    @(negedge clk);
    reset = r;
    Req   = q;
    e.grant = eg;
    e.sel   = es;
    e.busy  = eb;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic step_lock(input logic lk, input logic [3:0] q,
                           input logic [3:0] eg, input logic [1:0] es, input logic eb,
                           input string nm);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    Req   = q;
    lock  = lk;
    e.grant = eg;
    e.sel   = es;
    e.busy  = eb;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask
`endif

  initial begin
    logic [3:0] mask;
    logic [3:0] oh;
    reset = 1'b1;
    Req   = 4'b0000;
`ifdef MEM_ARB_LOCK_EN
    lock  = 1'b0;
`endif

    // 1: reset holds everything off even with all requesters active.
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_c1");
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_c2");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "reset_release_grant0");

    // 2: round-robin order. Each owner keeps the port for 3 cycles, then drops
    //    its request permanently.
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "rr_o0");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "rr_o0");
    for (int o = 1; o < 4; o++) begin
      mask = 4'b1111 << o;
      oh   = 4'b0001 << o;
      step(1'b0, mask, 4'b0000, 2'(o - 1), 1'b0, "rr_gap");
      for (int c = 0; c < 3; c++) begin
        step(1'b0, mask, oh, 2'(o), 1'b1, $sformatf("rr_o%0d", o));
      end
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "rr_final_gap");
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "rr_idle_hold_sel");

    // 3: burst limit. Two requesters alternate in bursts of exactly 8 cycles,
    //    separated by one gap cycle in which the selector keeps its value.
    for (int r = 0; r < 4; r++) begin
      oh = 4'b0001 << (r % 2);
      for (int c = 0; c < 8; c++) begin
        step(1'b0, 4'b0011, oh, 2'(r % 2), 1'b1, $sformatf("burst_r%0d_c%0d", r, c + 1));
      end
      step(1'b0, 4'b0011, 4'b0000, 2'(r % 2), 1'b0, $sformatf("burst_r%0d_gap", r));
    end

    // 4: a solo requester keeps the grant across count wrap and never gaps.
    //    Last=1, so requester 2 is found first.
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, $sformatf("solo_c%0d", c + 1));
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "solo_release_gap");
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "solo_idle");

    // 5: reset in the middle of a grant. After reset Last=3, so {3,1} requesting
    //    picks 1; a stale Last=1 would pick 3.
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, $sformatf("midrst_grant_c%0d", c + 1));
    end
    step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, "midrst_reset");
    step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, "midrst_regrant_last3");
    step(1'b0, 4'b1000, 4'b0000, 2'd1, 1'b0, "midrst_release_gap");
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "midrst_next_owner3");
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "midrst_gap");
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "midrst_idle");

`ifdef MEM_ARB_LOCK_EN
    // 6: Lock holds owner 0 past the burst limit. When Lock drops with the
    //    count saturated, owner 0 is preempted at once.
    for (int c = 0; c < 12; c++) begin
      step_lock(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("lock_c%0d", c + 1));
    end
    step_lock(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, "lock_drop_gap");
    step_lock(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "lock_next_owner1");
    step_lock(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "lock_release_gap");
`endif

    // Let the monitor drain the queue, within a fixed cycle budget.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
